// File: rtl/alu_pkg.sv
// Shared opcode encoding and flag-vector type for the pipelined ALU.
// The flag vector is packed as {z,n,c,v} everywhere in the datapath.
package alu_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_NOR  = 3'b101;
    localparam logic [2:0] OP_NAND = 3'b110;
    localparam logic [2:0] OP_NOT  = 3'b111;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } alu_flags_t;

    function automatic alu_flags_t make_flags(
        input logic z,
        input logic n,
        input logic c,
        input logic v
    );
        alu_flags_t f;
        f.z = z;
        f.n = n;
        f.c = c;
        f.v = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational WIDTH-bit ALU: eight ops, result plus {z,n,c,v} flags.
// SUB is formed as a + ~b + 1, so carry=1 means "no borrow".
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result,
    output alu_flags_t       flags
);

    localparam int M = WIDTH - 1;

    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] res_s;
    logic             carry_s;
    logic             ovf_s;

    // Operation select; carry/overflow stay 0 for the logic ops.
    always_comb begin
        sum_s   = '0;
        res_s   = '0;
        carry_s = 1'b0;
        ovf_s   = 1'b0;
        case (op)
            OP_AND:  res_s = a & b;
            OP_OR:   res_s = a | b;
            OP_ADD: begin
                sum_s   = {1'b0, a} + {1'b0, b};
                res_s   = sum_s[WIDTH-1:0];
                carry_s = sum_s[WIDTH];
                ovf_s   = (a[M] == b[M]) && (res_s[M] != a[M]);
            end
            OP_SUB: begin
                sum_s   = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
                res_s   = sum_s[WIDTH-1:0];
                carry_s = sum_s[WIDTH];
                ovf_s   = (a[M] != b[M]) && (res_s[M] != a[M]);
            end
            OP_XOR:  res_s = a ^ b;
            OP_NOR:  res_s = ~(a | b);
            OP_NAND: res_s = ~(a & b);
            OP_NOT:  res_s = ~a;
            default: res_s = '0;
        endcase
    end

    assign result = res_s;
    assign flags  = make_flags((res_s == '0), res_s[M], carry_s, ovf_s);

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline with accumulator feedback on operand A.
// Stage 1 only captures the request; stage 2 computes, registers result and updates the accumulator.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       alu_control,
    input  logic             use_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow,
    output logic [WIDTH-1:0] acc_out
);

    logic             s1_valid_r;
    logic [WIDTH-1:0] s1_a_r;
    logic [WIDTH-1:0] s1_b_r;
    logic [2:0]       s1_op_r;
    logic             s1_use_acc_r;

    logic             s2_valid_r;
    logic [WIDTH-1:0] s2_result_r;
    alu_flags_t       s2_flags_r;
    logic [WIDTH-1:0] acc_r;

    logic             s2_adv_s;
    logic             in_fire_s;
    logic [WIDTH-1:0] op_a_s;
    logic [WIDTH-1:0] core_result_s;
    alu_flags_t       core_flags_s;

    assign s2_adv_s  = s1_valid_r && (!s2_valid_r || out_ready);
    assign in_ready  = !s1_valid_r || s2_adv_s;
    assign in_fire_s = in_valid && in_ready;

    // The accumulator is read at compute time, so chained use_acc ops see the previous result.
    assign op_a_s = s1_use_acc_r ? acc_r : s1_a_r;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a      (op_a_s),
        .b      (s1_b_r),
        .op     (s1_op_r),
        .result (core_result_s),
        .flags  (core_flags_s)
    );

    // Stage 1: capture request on input transfer, empty when it moves to stage 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r   <= 1'b0;
            s1_a_r       <= '0;
            s1_b_r       <= '0;
            s1_op_r      <= 3'b000;
            s1_use_acc_r <= 1'b0;
        end else if (in_fire_s) begin
            s1_valid_r   <= 1'b1;
            s1_a_r       <= a;
            s1_b_r       <= b;
            s1_op_r      <= alu_control;
            s1_use_acc_r <= use_acc;
        end else if (s2_adv_s) begin
            s1_valid_r   <= 1'b0;
        end
    end

    // Stage 2: register result/flags and update the accumulator on advance; drain on output transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_r  <= 1'b0;
            s2_result_r <= '0;
            s2_flags_r  <= make_flags(1'b0, 1'b0, 1'b0, 1'b0);
            acc_r       <= '0;
        end else if (s2_adv_s) begin
            s2_valid_r  <= 1'b1;
            s2_result_r <= core_result_s;
            s2_flags_r  <= core_flags_s;
            acc_r       <= core_result_s;
        end else if (out_ready) begin
            s2_valid_r  <= 1'b0;
        end
    end

    assign out_valid = s2_valid_r;
    assign result    = s2_result_r;
    assign zero      = s2_flags_r.z;
    assign negative  = s2_flags_r.n;
    assign carry     = s2_flags_r.c;
    assign overflow  = s2_flags_r.v;
    assign acc_out   = acc_r;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed table plus hand sequences for alu_pipe (WIDTH=4), and a WIDTH=8 instance
// checked against an integer reference model under random stalls.
module tb_alu_pipe;
    import alu_pkg::*;

    logic clk;
    logic rst;

    logic       in_valid4, in_ready4, use_acc4, out_valid4, out_ready4;
    logic [3:0] a4, b4, result4, acc4;
    logic [2:0] op4;
    logic       zero4, neg4, carry4, ovf4;

    logic       in_valid8, in_ready8, use_acc8, out_valid8, out_ready8;
    logic [7:0] a8, b8, result8, acc8;
    logic [2:0] op8;
    logic       zero8, neg8, carry8, ovf8;

    int checks = 0;
    int errors = 0;

    alu_pipe #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .alu_control(op4), .use_acc(use_acc4),
        .out_valid(out_valid4), .out_ready(out_ready4), .result(result4),
        .zero(zero4), .negative(neg4), .carry(carry4), .overflow(ovf4), .acc_out(acc4)
    );

    alu_pipe #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .alu_control(op8), .use_acc(use_acc8),
        .out_valid(out_valid8), .out_ready(out_ready8), .result(result8),
        .zero(zero8), .negative(neg8), .carry(carry8), .overflow(ovf8), .acc_out(acc8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        logic       use_acc;
        logic [3:0] exp_res;
        logic [3:0] exp_flags;  // {z,n,c,v}
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one op with out_ready=1 and verify the two-cycle latency and the result.
    task automatic issue4(input vec_t v, input string name);
        @(negedge clk);
        a4 = v.a; b4 = v.b; op4 = v.op; use_acc4 = v.use_acc;
        in_valid4 = 1'b1; out_ready4 = 1'b1;
        #1 check({name, " in_ready"}, 32'(in_ready4), 32'd1);
        @(negedge clk);
        in_valid4 = 1'b0;
        check({name, " early_valid"}, 32'(out_valid4), 32'd0);
        @(negedge clk);
        check({name, " out_valid"}, 32'(out_valid4), 32'd1);
        check({name, " result"}, 32'(result4), 32'(v.exp_res));
        check({name, " flags"}, 32'({zero4, neg4, carry4, ovf4}), 32'(v.exp_flags));
    endtask

    function automatic logic [11:0] model8(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        int ia, ib, sa, sb, t;
        logic [7:0] r;
        logic c, v;
        ia = int'(a); ib = int'(b);
        sa = int'($signed(a)); sb = int'($signed(b));
        c = 1'b0; v = 1'b0; r = 8'h00;
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: begin
                t = ia + ib; r = 8'(t); c = (t > 255);
                t = sa + sb; v = (t > 127) || (t < -128);
            end
            3'd3: begin
                t = ia - ib; r = 8'(t); c = (ia >= ib);
                t = sa - sb; v = (t > 127) || (t < -128);
            end
            3'd4: r = a ^ b;
            3'd5: r = ~(a | b);
            3'd6: r = ~(a & b);
            default: r = ~a;
        endcase
        return {r, (r == 8'h00), r[7], c, v};
    endfunction

    logic [11:0] expq[$];
    logic [11:0] exp_e;
    logic [7:0]  macc;
    logic [7:0]  opa;
    int          accepted;

    initial begin
        vecs[0]  = '{4'b1100, 4'b1010, OP_AND,  1'b0, 4'b1000, 4'b0100};
        vecs[1]  = '{4'b1100, 4'b1010, OP_OR,   1'b0, 4'b1110, 4'b0100};
        vecs[2]  = '{4'b1100, 4'b1010, OP_ADD,  1'b0, 4'b0110, 4'b0011};
        vecs[3]  = '{4'b1100, 4'b1010, OP_SUB,  1'b0, 4'b0010, 4'b0010};
        vecs[4]  = '{4'b1100, 4'b1010, OP_XOR,  1'b0, 4'b0110, 4'b0000};
        vecs[5]  = '{4'b1100, 4'b1010, OP_NOR,  1'b0, 4'b0001, 4'b0000};
        vecs[6]  = '{4'b1100, 4'b1010, OP_NAND, 1'b0, 4'b0111, 4'b0000};
        vecs[7]  = '{4'b1100, 4'b1010, OP_NOT,  1'b0, 4'b0011, 4'b0000};
        vecs[8]  = '{4'b0111, 4'b0001, OP_ADD,  1'b0, 4'b1000, 4'b0101};
        vecs[9]  = '{4'b0010, 4'b0100, OP_SUB,  1'b0, 4'b1110, 4'b0100};
        vecs[10] = '{4'b1111, 4'b0001, OP_ADD,  1'b0, 4'b0000, 4'b1010};
        vecs[11] = '{4'b1111, 4'b0001, OP_ADD,  1'b1, 4'b0001, 4'b0000};
        vecs[12] = '{4'b0101, 4'b0101, OP_SUB,  1'b0, 4'b0000, 4'b1010};
        vecs[13] = '{4'b1000, 4'b0001, OP_SUB,  1'b0, 4'b0111, 4'b0011};
        vecs[14] = '{4'b0000, 4'b1111, OP_NOT,  1'b0, 4'b1111, 4'b0100};

        rst = 1'b1;
        in_valid4 = 1'b0; a4 = 4'h0; b4 = 4'h0; op4 = 3'd0; use_acc4 = 1'b0; out_ready4 = 1'b1;
        in_valid8 = 1'b0; a8 = 8'h00; b8 = 8'h00; op8 = 3'd0; use_acc8 = 1'b0; out_ready8 = 1'b1;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst out_valid", 32'(out_valid4), 32'd0);
        check("rst result", 32'(result4), 32'd0);
        check("rst flags", 32'({zero4, neg4, carry4, ovf4}), 32'd0);
        check("rst acc", 32'(acc4), 32'd0);
        check("rst out_valid8", 32'(out_valid8), 32'd0);
        rst = 1'b0;
        #1 check("rst in_ready", 32'(in_ready4), 32'd1);

        // Table: every op plus arithmetic boundaries
        for (int i = 0; i < 15; i++) begin
            issue4(vecs[i], $sformatf("vec%0d", i));
        end
        @(negedge clk);
        check("table acc_out", 32'(acc4), 32'hF);

        // Back-to-back accumulate chain
        a4 = 4'b0001; b4 = 4'b0001; op4 = OP_ADD; use_acc4 = 1'b0; in_valid4 = 1'b1;
        #1 check("acc1 in_ready", 32'(in_ready4), 32'd1);
        @(negedge clk);
        a4 = 4'b1001; b4 = 4'b0011; op4 = OP_ADD; use_acc4 = 1'b1;
        check("acc2 in_ready", 32'(in_ready4), 32'd1);
        @(negedge clk);
        in_valid4 = 1'b0; use_acc4 = 1'b0;
        check("acc first valid", 32'(out_valid4), 32'd1);
        check("acc first result", 32'(result4), 32'b0010);
        @(negedge clk);
        check("acc second valid", 32'(out_valid4), 32'd1);
        check("acc second result", 32'(result4), 32'b0101);
        check("acc acc_out", 32'(acc4), 32'b0101);
        @(negedge clk);
        check("acc drained", 32'(out_valid4), 32'd0);

        // Backpressure: two held, third refused until out_ready rises
        out_ready4 = 1'b0;
        a4 = 4'b0011; b4 = 4'b0001; op4 = OP_ADD; in_valid4 = 1'b1;
        #1 check("bp A in_ready", 32'(in_ready4), 32'd1);
        @(negedge clk);
        a4 = 4'b1010; b4 = 4'b0101; op4 = OP_XOR;
        check("bp B in_ready", 32'(in_ready4), 32'd1);
        check("bp B out_valid", 32'(out_valid4), 32'd0);
        @(negedge clk);
        a4 = 4'b1111; b4 = 4'b0110; op4 = OP_AND;
        check("bp C refused", 32'(in_ready4), 32'd0);
        check("bp hold1", 32'({out_valid4, result4}), 32'h14);
        @(negedge clk);
        check("bp hold2", 32'({out_valid4, result4}), 32'h14);
        check("bp still refused", 32'(in_ready4), 32'd0);
        out_ready4 = 1'b1;
        #1 check("bp ready again", 32'(in_ready4), 32'd1);
        check("bp A out", 32'({out_valid4, result4}), 32'h14);
        @(negedge clk);
        in_valid4 = 1'b0;
        check("bp B out", 32'({out_valid4, result4}), 32'h1F);
        @(negedge clk);
        check("bp C out", 32'({out_valid4, result4}), 32'h16);
        check("bp acc", 32'(acc4), 32'b0110);
        @(negedge clk);
        check("bp drained", 32'(out_valid4), 32'd0);

        // Asynchronous reset with two ops in flight
        out_ready4 = 1'b0;
        a4 = 4'b0100; b4 = 4'b0011; op4 = OP_ADD; in_valid4 = 1'b1;
        @(negedge clk);
        a4 = 4'b0001; b4 = 4'b0001; op4 = OP_OR;
        @(negedge clk);
        in_valid4 = 1'b0;
        check("mid out_valid before rst", 32'(out_valid4), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async rst out_valid", 32'(out_valid4), 32'd0);
        check("async rst result", 32'(result4), 32'd0);
        check("async rst acc", 32'(acc4), 32'd0);
        check("async rst in_ready", 32'(in_ready4), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        out_ready4 = 1'b1;
        issue4('{4'b0101, 4'b0010, OP_OR, 1'b0, 4'b0111, 4'b0000}, "post_rst");
        @(negedge clk);
        check("post_rst drained", 32'(out_valid4), 32'd0);

        // WIDTH=8 directed boundary
        a8 = 8'h80; b8 = 8'h01; op8 = OP_SUB; in_valid8 = 1'b1; out_ready8 = 1'b1;
        @(negedge clk);
        in_valid8 = 1'b0;
        @(negedge clk);
        check("w8 sub out_valid", 32'(out_valid8), 32'd1);
        check("w8 sub result", 32'(result8), 32'h7F);
        check("w8 sub flags", 32'({zero8, neg8, carry8, ovf8}), 32'b0011);
        @(negedge clk);

        // WIDTH=8 random ops with random stalls against the reference model
        macc = 8'h7F;
        accepted = 0;
        for (int cyc = 0; cyc < 8000 && accepted < 1000; cyc++) begin
            @(negedge clk);
            out_ready8 = ($urandom_range(0, 3) != 0);
            in_valid8  = ($urandom_range(0, 3) != 0);
            a8 = 8'($urandom); b8 = 8'($urandom); op8 = 3'($urandom);
            use_acc8 = ($urandom_range(0, 2) == 0);
            #1;
            if (out_valid8 && out_ready8) begin
                if (expq.size() == 0) begin
                    check("rand unexpected out", 32'(out_valid8), 32'd0);
                end else begin
                    exp_e = expq.pop_front();
                    check("rand out", 32'({result8, zero8, neg8, carry8, ovf8}), 32'(exp_e));
                end
            end
            if (in_valid8 && in_ready8) begin
                opa = use_acc8 ? macc : a8;
                exp_e = model8(opa, b8, op8);
                macc = exp_e[11:4];
                expq.push_back(exp_e);
                accepted++;
            end
        end
        for (int cyc = 0; cyc < 20 && expq.size() > 0; cyc++) begin
            @(negedge clk);
            in_valid8 = 1'b0;
            out_ready8 = 1'b1;
            #1;
            if (out_valid8) begin
                exp_e = expq.pop_front();
                check("rand drain out", 32'({result8, zero8, neg8, carry8, ovf8}), 32'(exp_e));
            end
        end
        check("rand accepted", 32'(accepted), 32'd1000);
        check("rand drained", 32'(expq.size()), 32'd0);
        check("rand acc", 32'(acc8), 32'(macc));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
